tick_period_meter: RTL and testbench
====================================

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 SHALL have parameter W, default 21: width of the cycle counter and of period_out.
REQ-002 SHALL have parameter N_EXP, default 20: expected tick period in clk cycles.
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive matching periods required for lock.
REQ-004 SHALL have parameter TIMEOUT, default 1000: cycles without an edge before timeout.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pulse_in, input, 1 bit: tick stream from a divider.
REQ-008 SHALL have port period_out, output, W bits: last measured edge-to-edge distance in cycles.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle strobe when period_out updates.
REQ-010 SHALL have port match, output, 1 bit: last measured period equals N_EXP.
REQ-011 SHALL have port locked, output, 1 bit: LOCK_CNT consecutive matches seen and no fault since.
REQ-012 SHALL have port timeout, output, 1 bit: sticky; no edge seen for TIMEOUT cycles.

Function
REQ-013 SHALL detect a rising edge when the sampled pulse_in is 1 and its registered previous value is 0; a level held high counts as one edge.
REQ-014 SHALL keep counter cnt; on an edge cnt<=1; otherwise cnt<=cnt+1, saturating at all-ones (no wrap).
REQ-015 SHALL keep state IDLE (no edge since reset or timeout), ARMED (one edge seen) and MEAS (at least one period measured); IDLE->ARMED on first edge, ARMED->MEAS on next edge, any->IDLE on timeout.
REQ-016 SHALL, on an edge in ARMED or MEAS, register period_out<=cnt and pulse valid high the following cycle (1-cycle latency from edge detect); no valid on the first edge after IDLE.
REQ-017 SHALL update match together with valid: match=1 iff period_out==N_EXP; match holds between strobes.
REQ-018 SHALL keep a match counter: +1 on a matching period (saturating at LOCK_CNT) and cleared on a mismatch; locked=1 once it reaches LOCK_CNT, and locked clears in the same cycle valid reports a mismatch.
REQ-019 SHALL set timeout, clear locked and the match counter, and enter IDLE when cnt reaches TIMEOUT in ARMED or MEAS; timeout stays set until the next edge, which also counts as the first edge (IDLE->ARMED).
REQ-020 SHALL give an edge priority over timeout when both occur in the same cycle.
REQ-021 SHALL report period_out as the saturated value if cnt saturated; a saturated value never matches unless N_EXP equals it.

Reset
REQ-022 SHALL, while rst=1 at a clk edge, clear period_out, valid, match, locked, timeout, cnt, the match counter and the previous-input register, and enter IDLE.
REQ-023 SHALL, on reset mid-measurement, discard the partial count; no valid until two edges are seen after reset.

Configuration
REQ-024 SHALL, with macro TICK_PERIOD_METER_SYNC_EN defined, pass pulse_in through a 2-flop synchronizer (reset to 0) before edge detection, adding 2 cycles of latency and no change to measured periods.
REQ-025 SHALL, without TICK_PERIOD_METER_SYNC_EN, sample pulse_in directly (same-clock source).

Verification
REQ-026 Ticks every 20 cycles, 1-cycle high, N_EXP=20 -> first valid after the 2nd edge with period_out=20, match=1; locked=1 on the 4th valid.
REQ-027 Locked stream, then one gap of 21 cycles -> valid with period_out=21, match=0, locked=0 in that cycle; relock after 4 more periods of 20.
REQ-028 Pulse_in stuck low after lock, TIMEOUT=1000 -> timeout=1, locked=0 exactly 999 cycles after the last edge (cnt reaches 1000); the next edge clears timeout with no valid.
REQ-029 Pulse_in held high for 5 cycles every 20 cycles -> one edge per period; period_out=20.
REQ-030 rst asserted 10 cycles into a period -> all outputs 0 next cycle; first valid only after the 2nd post-reset edge.
REQ-031 With SYNC_EN defined, repeat REQ-026 -> identical period_out values, with valid delayed 2 cycles.

Source files
------------

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the edge-to-edge distance of a tick stream and flags match, lock and timeout.
//   clk        : single clock, all logic on its rising edge
//   rst        : synchronous active-high reset
//   pulse_in   : tick stream from a divider
//   period_out : last measured edge-to-edge distance in cycles (W bits, saturating)
//   valid      : one-cycle strobe when period_out updates
//   match      : last measured period equals N_EXP
//   locked     : LOCK_CNT consecutive matches seen and no fault since
//   timeout    : sticky, no edge seen for TIMEOUT cycles; cleared by the next edge
//   Optional macro TICK_PERIOD_METER_SYNC_EN adds a 2-flop input synchronizer.
module tick_period_meter #(
    parameter int W        = 21,
    parameter int N_EXP    = 20,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pulse_in,
    output logic [W-1:0] period_out,
    output logic         valid,
    output logic         match,
    output logic         locked,
    output logic         timeout
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_t;
    state_t state_q;
    logic [W-1:0] cnt_q, cnt_d, period_q;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic prev_q, pulse_s, edge_s, hit, tmo;
    logic valid_q, match_q, locked_q, timeout_q;
`ifdef TICK_PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], pulse_in};
    end
    assign pulse_s = sync_q[1];
`else
    assign pulse_s = pulse_in;
`endif
    // The measured period is the count held when the closing edge arrives.
    always_comb begin
        edge_s = pulse_s & ~prev_q;
        cnt_d  = edge_s ? W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        hit    = int'(cnt_q) == N_EXP;
        mcnt_d = hit ? (int'(mcnt_q) >= LOCK_CNT ? mcnt_q : mcnt_q + 1'b1) : '0;
        // Timeout fires on the cycle the count would reach TIMEOUT; an edge wins.
        tmo    = !edge_s && state_q != IDLE && int'(cnt_d) == TIMEOUT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            period_q  <= '0;
            mcnt_q    <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            prev_q  <= pulse_s;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            if (edge_s) begin
                timeout_q <= 1'b0;
                if (state_q == IDLE) begin
                    state_q <= ARMED;
                end else begin
                    state_q  <= MEAS;
                    period_q <= cnt_q;
                    valid_q  <= 1'b1;
                    match_q  <= hit;
                    mcnt_q   <= mcnt_d;
                    locked_q <= int'(mcnt_d) == LOCK_CNT;
                end
            end else if (tmo) begin
                state_q   <= IDLE;
                timeout_q <= 1'b1;
                locked_q  <= 1'b0;
                mcnt_q    <= '0;
            end
        end
    end
    assign period_out = period_q;
    assign valid      = valid_q;
    assign match      = match_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: directed self-checking bench for tick_period_meter.
module tb_tick_period_meter;
    logic        clk = 1'b0;
    logic        rst, pulse_in;
    logic [20:0] period_out;
    logic        valid, match, locked, timeout;
    logic [3:0]  s_period;
    logic        s_valid, s_match, s_locked, s_timeout;
`ifdef TICK_PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    int n_chk = 0, n_pass = 0, extra_v;
    logic        fv, fm, fl, fto, fsm;
    logic [20:0] fp;
    logic [3:0]  fsp;

    tick_period_meter #(.W(21), .N_EXP(20), .LOCK_CNT(4), .TIMEOUT(1000)) u_dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .period_out(period_out),
        .valid(valid), .match(match), .locked(locked), .timeout(timeout));

    // Narrow counter: a 20-cycle period saturates at 15, which equals N_EXP here.
    tick_period_meter #(.W(4), .N_EXP(15), .LOCK_CNT(2), .TIMEOUT(200)) u_sat (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .period_out(s_period),
        .valid(s_valid), .match(s_match), .locked(s_locked), .timeout(s_timeout));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic p);
        @(negedge clk);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    // One period of len cycles starting with an edge; captures outputs when that edge is reported.
    task automatic period(input int len, input int hi);
        extra_v = 0;
        for (int i = 0; i < len; i++) begin
            cyc(i < hi);
            if (i == LAT) begin
                fv = valid; fp = period_out; fm = match; fl = locked; fto = timeout;
                fsp = s_period; fsm = s_match;
            end else begin
                extra_v += int'(valid);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        rst = 1'b1;
        pulse_in = 1'b0;
        repeat (3) cyc(1'b0);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) cyc(1'b0);
        period(20, 1);
        check("first_edge_valid", fv, 0);
        for (int n = 1; n <= 4; n++) begin
            period(20, 1);
            check("lock_valid", fv, 1);
            check("lock_period", fp, 20);
            check("lock_match", fm, 1);
            check("lock_locked", fl, n == 4);
            check("lock_strobe_len", extra_v, 0);
            if (n == 1) begin
                check("sat_period", fsp, 15);
                check("sat_match", fsm, 1);
            end
        end
        check("match_hold", match, 1);
        period(21, 1);
        check("pre_gap_locked", fl, 1);
        period(20, 1);
        check("gap_valid", fv, 1);
        check("gap_period", fp, 21);
        check("gap_match", fm, 0);
        check("gap_locked", fl, 0);
        for (int n = 1; n <= 4; n++) begin
            period(20, 1);
            check("relock_match", fm, 1);
            check("relock_locked", fl, n == 4);
        end
        for (int n = 0; n < 2; n++) begin
            period(20, 5);
            check("wide_period", fp, 20);
            check("wide_match", fm, 1);
            check("wide_locked", fl, 1);
            check("wide_one_edge", extra_v, 0);
        end
        cyc(1'b1);
        for (int k = 1; k <= 1005; k++) begin
            cyc(1'b0);
            if (k == 998 + LAT) begin
                check("pre_timeout", timeout, 0);
                check("pre_timeout_locked", locked, 1);
            end
            if (k == 999 + LAT) begin
                check("timeout_set", timeout, 1);
                check("timeout_locked", locked, 0);
            end
        end
        check("timeout_sticky", timeout, 1);
        period(20, 1);
        check("post_timeout_valid", fv, 0);
        check("post_timeout_clear", fto, 0);
        period(20, 1);
        check("post_timeout_meas_valid", fv, 1);
        check("post_timeout_period", fp, 20);
        check("post_timeout_locked", fl, 0);
        cyc(1'b1);
        repeat (9) cyc(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midreset");
        rst = 1'b0;
        period(20, 1);
        check("rst_first_edge_valid", fv, 0);
        period(20, 1);
        check("rst_second_edge_valid", fv, 1);
        check("rst_second_edge_period", fp, 20);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
